// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel programmable clock divider.
// Ratio encodings with special meaning, plus the div_ratio bus slice locator.
package clk_div_pkg;

  localparam int RATIO_OFF    = 0;
  localparam int RATIO_BYPASS = 1;

  // Low bit index of channel ch's ratio field within the packed div_ratio bus.
  function automatic int ratio_lo(input int ch, input int cnt_w);
    return ch * cnt_w;
  endfunction

endpackage

// File: rtl/prog_clk_div_chan.sv
// One divider channel: period counter, active/shadow ratio pair and registered outputs.
// A new ratio is only adopted at a period boundary, on sync, or when the channel is idle.
module prog_clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             sync,
  input  logic [CNT_W-1:0] ratio,
  output logic             div_out,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] act_reg, act_next;
  logic [CNT_W-1:0] shd_reg, shd_next;
  logic             pend_reg, pend_next;
  logic             div_out_reg, div_out_next;
  logic             tick_reg, tick_next;

  logic             active;
  logic             at_wrap;
  logic             pend_eff;
  logic             apply;
  logic [CNT_W-1:0] shd_eff;
  logic [CNT_W-1:0] last_cnt;
  logic [CNT_W:0]   high_len;

  always_comb begin
    active   = (act_reg != CNT_W'(RATIO_OFF));
    last_cnt = act_reg - CNT_W'(RATIO_BYPASS);
    at_wrap  = active && (cnt_reg == last_cnt);
    // A load arriving on the apply edge is used directly, bypassing the shadow.
    pend_eff = pend_reg || load;
    shd_eff  = load ? ratio : shd_reg;
    apply    = pend_eff && (!active || (en && (at_wrap || sync)));

    cnt_next  = cnt_reg;
    act_next  = act_reg;
    shd_next  = shd_eff;
    pend_next = pend_eff;

    if (apply) begin
      act_next  = shd_eff;
      cnt_next  = '0;
      pend_next = 1'b0;
    end else if (en && active) begin
      if (at_wrap || sync) cnt_next = '0;
      else                 cnt_next = cnt_reg + CNT_W'(1);
    end

    // High for ceil(R/2) cycles; the extra bit keeps R = 2**CNT_W-1 from overflowing.
    high_len     = ({1'b0, act_next} + (CNT_W+1)'(1)) >> 1;
    div_out_next = (act_next != CNT_W'(RATIO_OFF)) && ({1'b0, cnt_next} < high_len);
    tick_next    = (act_next != CNT_W'(RATIO_OFF)) && (cnt_next == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg     <= '0;
      act_reg     <= '0;
      shd_reg     <= '0;
      pend_reg    <= 1'b0;
      div_out_reg <= 1'b0;
      tick_reg    <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      act_reg     <= act_next;
      shd_reg     <= shd_next;
      pend_reg    <= pend_next;
      div_out_reg <= div_out_next;
      tick_reg    <= tick_next;
    end
  end

  assign div_out = div_out_reg;
  assign tick    = tick_reg;

endmodule

// File: rtl/prog_clk_divider.sv
// Multi-channel programmable clock divider: one independent divider channel per
// ratio slice, with shared enable, load and phase-align controls.
module prog_clk_divider
  import clk_div_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      load,
  input  logic                      sync,
  input  logic [CHANNELS*CNT_W-1:0] div_ratio,
  output logic [CHANNELS-1:0]       div_out,
  output logic [CHANNELS-1:0]       tick
);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      prog_clk_div_chan #(
        .CNT_W (CNT_W)
      ) u_chan (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .load    (load),
        .sync    (sync),
        .ratio   (div_ratio[ratio_lo(gi, CNT_W) +: CNT_W]),
        .div_out (div_out[gi]),
        .tick    (tick[gi])
      );
    end
  endgenerate

endmodule
